dma_s2mm_arbiter: RTL
=====================

DMA_S2MM_ARBITER -- requirements
Module: dma_s2mm_arbiter

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 32: DataMover address width.
REQ-002 SHALL have parameter C_AXIS_WIDTH, default 64: data width in bits.
REQ-003 SHALL have parameter C_NUM_CH, default 2, legal 2..8: number of requester channels.
REQ-004 SHALL have parameter C_TAG_DEPTH, default 16, power of 2: maximum outstanding commands.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, reset, synchronous, active-low.
REQ-006 SHALL have per-channel command ports, packed [C_NUM_CH-1:0]: s_cmd_tdata in C_ADDR_WIDTH+48; s_cmd_tvalid in; s_cmd_tready out.
REQ-007 SHALL have per-channel data ports: s_tdata in C_AXIS_WIDTH; s_tlast in; s_tvalid in; s_tready out.
REQ-008 SHALL have per-channel status ports: s_sts_tdata out 8; s_sts_tkeep out 1; s_sts_tlast out; s_sts_tvalid out; s_sts_tready in.
REQ-009 SHALL have shared DataMover ports: m_cmd_tdata out C_ADDR_WIDTH+48, m_cmd_tvalid out, m_cmd_tready in; m_tdata out, m_tlast out, m_tvalid out, m_tready in; m_sts_tdata in 8, m_sts_tkeep in 1, m_sts_tlast in, m_sts_tvalid in, m_sts_tready out.
REQ-010 SHALL have outputs outstanding out $clog2(C_TAG_DEPTH)+1, the tag count, and sts_orphan out 1, a sticky error flag.

Function
REQ-011 SHALL use FSM states ST_IDLE, ST_CMD, ST_DATA, with grant register grant_q of width $clog2(C_NUM_CH).
REQ-012 In ST_IDLE, SHALL select round-robin the first channel with s_cmd_tvalid=1, searching from last_grant+1 with wrap at C_NUM_CH-1 to 0; SHALL register grant_q and last_grant and go to ST_CMD next cycle; with no request, SHALL stay in ST_IDLE.
REQ-013 In ST_CMD, SHALL drive m_cmd_tdata=s_cmd_tdata[grant_q], m_cmd_tvalid=s_cmd_tvalid[grant_q] AND tag FIFO not full, and s_cmd_tready[grant_q]=m_cmd_tready AND tag FIFO not full; all other s_cmd_tready SHALL be 0.
REQ-014 On a command handshake, SHALL push grant_q into the tag FIFO and go to ST_DATA.
REQ-015 In ST_DATA, SHALL pass s_tdata/s_tlast/s_tvalid of grant_q to m_*, and m_tready to s_tready[grant_q]; other s_tready SHALL be 0; outside ST_DATA, m_tvalid and all s_tready SHALL be 0.
REQ-016 On a data handshake with s_tlast=1, SHALL go to ST_IDLE; the minimum gap between bursts SHALL be 2 cycles (IDLE, CMD).
REQ-017 Status routing SHALL be combinational: with the tag FIFO non-empty and head=h, SHALL present m_sts_* on s_sts_*[h], with other s_sts_tvalid 0, and m_sts_tready=s_sts_tready[h].
REQ-018 SHALL pop the tag FIFO on a status handshake with m_sts_tlast=1.
REQ-019 With the tag FIFO empty, SHALL hold m_sts_tready=1, discard status, drive no s_sts_tvalid, and set sts_orphan=1 until reset.
REQ-020 On a simultaneous push and pop, outstanding SHALL be unchanged; with the FIFO empty, a push SHALL NOT be popped in the same cycle.
REQ-021 With the FIFO full, SHALL hold the command in ST_CMD without timeout; the grant SHALL NOT change.
REQ-022 SHALL NOT re-arbitrate until the tlast of the granted burst; s_cmd_tvalid dropping in ST_CMD SHALL NOT be a protocol error, and the FSM SHALL wait.

Reset
REQ-023 While rst_n=0 at clk, SHALL set state=ST_IDLE, grant_q=0, last_grant=C_NUM_CH-1, empty the tag FIFO, and set outstanding=0 and sts_orphan=0.
REQ-024 During and after reset, all tvalid/tready outputs SHALL be 0, except m_sts_tready=1 (per REQ-019); reset mid-burst SHALL abandon the burst.

Structure
REQ-025 SHALL place the state enum type and the localparams C_CMD_WIDTH=C_ADDR_WIDTH+48 and C_STS_WIDTH=8 in package dma_s2mm_pkg.
REQ-026 SHALL implement the tag FIFO as sub-module dma_tag_fifo: register-based, with count output and synchronous reset.
REQ-027 SHALL keep round-robin select and all muxes in one always_comb, and the FSM in one always_ff.

Verification
REQ-028 Both channels request at once after reset -> ch0 is granted first, then ch1; m_cmd order 0,1; status order 0,1.
REQ-029 Only ch1 requests, 3 bursts of 16 beats -> 3 commands all to ch1; each data burst is exactly 16 beats; outstanding peaks at 3 when status is withheld.
REQ-030 Status withheld with C_TAG_DEPTH=4 and 5 commands queued -> 5th command is stalled in ST_CMD (m_cmd_tvalid=0); one status pop releases it within 1 cycle.
REQ-031 m_sts_tvalid=1 with 0 outstanding -> m_sts_tready=1, no s_sts_tvalid, sts_orphan=1, and it stays 1 until rst_n=0.
REQ-032 rst_n=0 at beat 7 of a burst -> next cycle state=ST_IDLE, outstanding=0, all s_tready=0; a new request is granted 2 cycles after release.
REQ-033 m_tready toggles 1/0 each cycle during a burst -> no beat is lost or duplicated; data order matches the source.

Source files
------------

// File: rtl/dma_s2mm_pkg.sv
// Shared types and constants for the S2MM DataMover command/data/status arbiter.
// The command width follows the DataMover layout: address plus 48 control bits.
package dma_s2mm_pkg;

    localparam int C_CMD_OVERHEAD   = 48;
    localparam int C_STS_WIDTH      = 8;
    localparam int C_DEF_ADDR_WIDTH = 32;
    localparam int C_CMD_WIDTH      = C_DEF_ADDR_WIDTH + C_CMD_OVERHEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/dma_tag_fifo.sv
// Register-based FIFO of channel tags, one entry per command still awaiting status.
// Push is ignored when full and pop is ignored when empty.
module dma_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dma_s2mm_arbiter.sv
// Round-robin arbiter sharing one S2MM DataMover between C_NUM_CH requesters.
// Status beats are steered back to their owner through a FIFO of command tags.
module dma_s2mm_arbiter
    import dma_s2mm_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_AXIS_WIDTH = 64,
    parameter int C_NUM_CH     = 2,
    parameter int C_TAG_DEPTH  = 16
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic [C_NUM_CH-1:0][C_ADDR_WIDTH+C_CMD_OVERHEAD-1:0]  s_cmd_tdata,
    input  logic [C_NUM_CH-1:0]                                   s_cmd_tvalid,
    output logic [C_NUM_CH-1:0]                                   s_cmd_tready,
    input  logic [C_NUM_CH-1:0][C_AXIS_WIDTH-1:0]                 s_tdata,
    input  logic [C_NUM_CH-1:0]                                   s_tlast,
    input  logic [C_NUM_CH-1:0]                                   s_tvalid,
    output logic [C_NUM_CH-1:0]                                   s_tready,
    output logic [C_NUM_CH-1:0][C_STS_WIDTH-1:0]                  s_sts_tdata,
    output logic [C_NUM_CH-1:0]                                   s_sts_tkeep,
    output logic [C_NUM_CH-1:0]                                   s_sts_tlast,
    output logic [C_NUM_CH-1:0]                                   s_sts_tvalid,
    input  logic [C_NUM_CH-1:0]                                   s_sts_tready,
    output logic [C_ADDR_WIDTH+C_CMD_OVERHEAD-1:0]                m_cmd_tdata,
    output logic                                                  m_cmd_tvalid,
    input  logic                                                  m_cmd_tready,
    output logic [C_AXIS_WIDTH-1:0]                               m_tdata,
    output logic                                                  m_tlast,
    output logic                                                  m_tvalid,
    input  logic                                                  m_tready,
    input  logic [C_STS_WIDTH-1:0]                                m_sts_tdata,
    input  logic                                                  m_sts_tkeep,
    input  logic                                                  m_sts_tlast,
    input  logic                                                  m_sts_tvalid,
    output logic                                                  m_sts_tready,
    output logic [$clog2(C_TAG_DEPTH):0]                          outstanding,
    output logic                                                  sts_orphan
);

    localparam int GW = $clog2(C_NUM_CH);

    state_t        state;
    state_t        next_state;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] rr_sel;
    logic [GW-1:0] rr_cand;
    logic          req_any;
    logic          cmd_hs;
    logic          data_last_hs;
    logic          tag_pop;
    logic          tag_full;
    logic          tag_empty;
    logic [GW-1:0] tag_head;

    dma_tag_fifo #(
        .DEPTH (C_TAG_DEPTH),
        .WIDTH (GW)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_hs),
        .push_data (grant_q),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (outstanding)
    );

    always_comb begin
        next_state   = state;
        rr_sel       = grant_q;
        rr_cand      = '0;
        req_any      = 1'b0;
        cmd_hs       = 1'b0;
        data_last_hs = 1'b0;
        tag_pop      = 1'b0;
        s_cmd_tready = '0;
        m_cmd_tdata  = s_cmd_tdata[grant_q];
        m_cmd_tvalid = 1'b0;
        s_tready     = '0;
        m_tdata      = s_tdata[grant_q];
        m_tlast      = s_tlast[grant_q];
        m_tvalid     = 1'b0;
        s_sts_tdata  = '0;
        s_sts_tkeep  = '0;
        s_sts_tlast  = '0;
        s_sts_tvalid = '0;
        m_sts_tready = 1'b1;

        // Search starts one past the previous winner so every channel gets a turn.
        for (int i = 1; i <= C_NUM_CH; i++) begin
            rr_cand = GW'((int'(last_grant) + i) % C_NUM_CH);
            if (!req_any && s_cmd_tvalid[rr_cand]) begin
                req_any = 1'b1;
                rr_sel  = rr_cand;
            end
        end

        case (state)
            ST_IDLE: begin
                if (req_any) next_state = ST_CMD;
            end
            ST_CMD: begin
                m_cmd_tvalid          = s_cmd_tvalid[grant_q] && !tag_full;
                s_cmd_tready[grant_q] = m_cmd_tready && !tag_full;
                cmd_hs                = m_cmd_tvalid && m_cmd_tready;
                if (cmd_hs) next_state = ST_DATA;
            end
            ST_DATA: begin
                m_tvalid          = s_tvalid[grant_q];
                s_tready[grant_q] = m_tready;
                data_last_hs      = m_tvalid && m_tready && m_tlast;
                if (data_last_hs) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase

        // With no tag queued the status is orphaned and silently absorbed.
        if (!tag_empty) begin
            s_sts_tdata[tag_head]  = m_sts_tdata;
            s_sts_tkeep[tag_head]  = m_sts_tkeep;
            s_sts_tlast[tag_head]  = m_sts_tlast;
            s_sts_tvalid[tag_head] = m_sts_tvalid;
            m_sts_tready           = s_sts_tready[tag_head];
            tag_pop                = m_sts_tvalid && m_sts_tready && m_sts_tlast;
        end

        if (!rst_n) begin
            s_cmd_tready = '0;
            m_cmd_tvalid = 1'b0;
            cmd_hs       = 1'b0;
            s_tready     = '0;
            m_tvalid     = 1'b0;
            s_sts_tvalid = '0;
            m_sts_tready = 1'b1;
            tag_pop      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            last_grant <= GW'(C_NUM_CH - 1);
            sts_orphan <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && req_any) begin
                grant_q    <= rr_sel;
                last_grant <= rr_sel;
            end
            if (tag_empty && m_sts_tvalid) begin
                sts_orphan <= 1'b1;
            end
        end
    end

endmodule
